// File: rtl/seq_checker.sv
// Receive-side monitor for the 3-bit custom-sequence counter.
// Optional saturating error counter: define SEQ_CHK_ERRCNT_EN.
module seq_checker #(
  parameter int LOCK_CNT    = 3,
  parameter int UNLOCK_ERRS = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Q_A,
  input  logic       Q_B,
  input  logic       Q_C,
  output logic [2:0] pos,
  output logic       locked,
  output logic       err,
`ifdef SEQ_CHK_ERRCNT_EN
  output logic       wrap,
  output logic [ERR_CNT_W-1:0] err_cnt
`else
  output logic       wrap
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [2:0] LOCK_N  = LOCK_CNT[2:0];
  localparam logic [2:0] UNLCK_N = UNLOCK_ERRS[2:0];

  state_t     state_r;
  state_t     state_nx;
  logic [2:0] cur_r;
  logic [2:0] prev_r;
  logic [2:0] good_r;
  logic [2:0] good_nx;
  logic [2:0] bad_r;
  logic [2:0] bad_nx;

  logic [2:0] cur_pos;
  logic [2:0] prev_pos;
  logic [2:0] succ;
  logic       cur_vld;
  logic       prev_vld;
  logic       legal;
  logic [2:0] good_inc;
  logic [2:0] bad_inc;

  logic [2:0] pos_nx;
  logic       locked_nx;
  logic       err_nx;
  logic       wrap_nx;

  // 000 is the idle code; everything else maps to a ring position.
  function automatic logic [2:0] dec(
    input logic [2:0] c
  );
    logic [2:0] p;
    p = 3'd7;
    case (c)
      3'b011:  p = 3'd0;
      3'b010:  p = 3'd1;
      3'b110:  p = 3'd2;
      3'b111:  p = 3'd3;
      3'b101:  p = 3'd4;
      3'b100:  p = 3'd5;
      3'b001:  p = 3'd6;
      default: p = 3'd7;
    endcase
    return p;
  endfunction

  // Transition legality of the newest sample against the one before it.
  always_comb begin
    cur_pos  = dec(cur_r);
    prev_pos = dec(prev_r);
    cur_vld  = (cur_r != 3'b000);
    prev_vld = (prev_r != 3'b000);
    succ     = (prev_pos == 3'd6) ?
               3'd0 : prev_pos + 3'd1;
    legal    = cur_vld && prev_vld &&
               (cur_pos == succ);
    good_inc = (good_r == 3'd7) ?
               good_r : good_r + 3'd1;
    bad_inc  = (bad_r == 3'd7) ?
               bad_r : bad_r + 3'd1;
  end

  // Two-deep sample history of the counter code.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_r  <= 3'b000;
      prev_r <= 3'b000;
    end else begin
      cur_r  <= {Q_C, Q_B, Q_A};
      prev_r <= cur_r;
    end
  end

  // FSM state and lock-qualification counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      good_r  <= 3'd0;
      bad_r   <= 3'd0;
    end else begin
      state_r <= state_nx;
      good_r  <= good_nx;
      bad_r   <= bad_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    good_nx  = good_r;
    bad_nx   = bad_r;
    unique case (1'b1)
      (state_r == IDLE): begin
        if (cur_vld) begin
          state_nx = HUNT;
          good_nx  = 3'd0;
          bad_nx   = 3'd0;
        end
      end
      (state_r == HUNT): begin
        if (!cur_vld) begin
          state_nx = IDLE;
          good_nx  = 3'd0;
        end else if (legal) begin
          good_nx = good_inc;
          if (good_inc >= LOCK_N) begin
            state_nx = LOCKED;
            bad_nx   = 3'd0;
          end
        end else begin
          good_nx = 3'd0;
        end
      end
      (state_r == LOCKED): begin
        if (!cur_vld) begin
          state_nx = IDLE;
          bad_nx   = 3'd0;
        end else if (legal) begin
          bad_nx = 3'd0;
        end else begin
          bad_nx = bad_inc;
          if (bad_inc >= UNLCK_N) begin
            state_nx = HUNT;
            good_nx  = 3'd0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        good_nx  = 3'd0;
        bad_nx   = 3'd0;
      end
    endcase
  end

  // Output decode for the sample being judged this cycle.
  always_comb begin
    pos_nx    = cur_pos;
    locked_nx = (state_nx == LOCKED);
    err_nx    = (state_r == LOCKED) &&
                cur_vld && !legal;
    wrap_nx   = (state_r == LOCKED) &&
                legal && (prev_pos == 3'd6);
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos    <= 3'd7;
      locked <= 1'b0;
      err    <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      pos    <= pos_nx;
      locked <= locked_nx;
      err    <= err_nx;
      wrap   <= wrap_nx;
    end
  end

`ifdef SEQ_CHK_ERRCNT_EN
  // Saturating error tally, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_nx && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule
